dot_product_engine: RTL
=======================

// Module: dot_product_engine
// PURPOSE
//  Parametrised N-lane signed fixed-point dot-product engine with a pipelined adder tree.
//  Has multi-beat accumulation for vectors longer than LANES.
//  Results go into a DEPTH-entry circular result FIFO (memory_wrapper_2port), read one per request.
//  Next-generation DNN datapath core: credit-based flow control, concurrent read/write, no fixed fill/drain phases.
// PARAMETERS
//  LANES     4    elements per beat; power of 2, >=2; LOG2L = $clog2(LANES)
//  DW        16   signed input element width
//  OW        32   stored/output result width
//  DEPTH     64   result FIFO entries; power of 2
//  LOGDEPTH  6    $clog2(DEPTH)
// PORTS
//  clk            in   1               clock
//  rst_n          in   1               asynchronous, active-low reset
//  EN_mac         in   1               beat request; accepted when EN_mac && RDY_mac
//  mac_vecA       in   LANES*DW        packed vector A, lane i = [i*DW +: DW], signed
//  mac_vecB       in   LANES*DW        packed vector B, same packing
//  mac_last       in   1               1 = final beat of this dot product (tie 1 for single-beat)
//  RDY_mac        out  1               engine can accept a beat this cycle
//  EN_readMem     in   1               pop request for oldest result
//  VALID_memVal   out  1               memVal_data valid this cycle (1-cycle pulse)
//  memVal_data    out  OW              popped result, signed
//  occupancy      out  LOGDEPTH+1      results stored in FIFO, 0..DEPTH
// BEHAVIOUR
//  Reset values
//   - All outputs 0 except RDY_mac = 1.
//   - All pipeline valids, accumulator, pointers and counters are cleared.
//   - Memory contents are not cleared and are unreadable until rewritten.
//  Pipeline (E = accepting edge)
//   - Edge E: LANES signed products (2*DW bits) are registered.
//   - Edges E+1..E+LOG2L: adder-tree levels, one level per stage.
//   - Edge E+LOG2L+1: accumulator stage.
//   - Edge E+LOG2L+2: FIFO write, if the beat had mac_last = 1.
//   - Default configuration writes at E+4. The pipeline never stalls; one beat per cycle sustained.
//  Arithmetic
//   - Internal width IW = 2*DW + LOG2L + 8. Sign-extended at every level, so no internal overflow.
//   - Beat with mac_last = 0: acc <= acc + treesum, nothing is written.
//   - Beat with mac_last = 1: result = acc + treesum is sent to the FIFO and acc <= 0 in the same edge.
//   - Narrowing IW -> OW is defined under CONFIGURATION.
//  Flow control
//   - pending = accepted mac_last beats not yet written; ranges 0..LOG2L+2.
//   - RDY_mac = (occupancy + pending) < DEPTH. An accepted result always has a slot.
//   - EN_mac while RDY_mac = 0 is ignored and its data is dropped.
//   - mac_last = 0 beats are also gated by RDY_mac.
//  FIFO
//   - wr_ptr and rd_ptr are LOGDEPTH bits and wrap DEPTH-1 -> 0.
//   - Full when occupancy = DEPTH; empty when occupancy = 0.
//   - Pop occurs when EN_readMem && occupancy != 0. It drives memory cenA and advances rd_ptr.
//   - The cycle after a pop: VALID_memVal = 1 and memVal_data = entry.
//   - EN_readMem while empty: ignored, VALID_memVal = 0.
//   - memVal_data holds its last value while VALID_memVal = 0.
//  Simultaneous events
//   - Write and pop in the same cycle: occupancy unchanged, both pointers advance.
//   - Pop at occupancy = 1 with a concurrent write: the pop returns the old entry; the new entry remains.
//   - Write and pop to the same address never coincide.
//  Reset mid-operation
//   - In-flight beats and a partial accumulation are discarded.
//   - A pending VALID_memVal pulse is suppressed.
// CONFIGURATION
//  Macro DPE_SATURATE_EN
//   - Defined: IW -> OW saturates to [-2^(OW-1), 2^(OW-1)-1].
//   - Undefined: keeps the low OW bits (two's-complement wrap).
//  Timing, ports and flow control are identical in both builds.
// TESTING
//  T1 single beat:
//   - Stimulus: A = {1,2,3,4}, B = {5,6,7,8}, last = 1.
//   - Response: occupancy 0 -> 1 at E+4; pop gives VALID_memVal = 1, memVal_data = 70 one cycle later.
//  T2 signed:
//   - Stimulus: A = {-2,3,-1,0}, B = {4,5,7,9}, last = 1.
//   - Response: pop returns 0 (-8 + 15 - 7 = 0).
//   - Stimulus: A = {-3,0,0,0}, B = {5,0,0,0}.
//   - Response: 0xFFFFFFF1.
//  T3 accumulate:
//   - Stimulus: 3 beats of A = B = all 1, last = 0,0,1.
//   - Response: exactly one entry = 12; occupancy increments once.
//  T4 full/empty:
//   - Stimulus: EN_mac held high, last = 1, no reads.
//   - Response: RDY_mac drops after exactly 64 acceptances; occupancy settles at 64; extra EN_mac ignored.
//   - Stimulus: 64 pops, then EN_readMem at empty.
//   - Response: results in order; VALID_memVal stays 0 at empty.
//  T5 concurrency/wrap:
//   - Stimulus: 200 beats with random pops, including same-cycle push+pop at occupancy 1 and 64.
//   - Response: occupancy matches a model; data matches in order across pointer wrap.
//   - Stimulus: rst_n pulse mid-stream.
//   - Response: occupancy = 0, RDY_mac = 1, no VALID_memVal.
//  T6 saturation:
//   - Stimulus: all lanes A = B = 0x7FFF.
//   - Response: with DPE_SATURATE_EN, 0x7FFFFFFF; without it, 0xFFFC0004.
//   - Stimulus: A = 0x8000 in lane 0, B = 0x8000 x4, acc over 4 beats.
//   - Response: wrap vs saturate checked.

Source files
------------

// File: rtl/dot_product_engine.sv
// ============================================================================
// dot_product_engine
//
// Signed fixed-point dot-product engine. Each accepted beat multiplies LANES
// pairs of DW-bit signed elements, reduces them through a pipelined adder
// tree (one level per stage) and adds the tree sum into an accumulator.
// A beat flagged mac_last closes the dot product. Its narrowed result is
// written into a DEPTH-entry circular result FIFO, and the accumulator
// restarts from zero on the same edge. Results are popped one per
// EN_readMem request.
//
// Pipeline timing (E = accepting edge):
//   E              : products registered
//   E+1..E+LOG2L   : adder-tree levels
//   E+LOG2L+1      : accumulator / result register
//   E+LOG2L+2      : FIFO write
//
// Flow control: RDY_mac is high while (occupancy + pending) < DEPTH.
// "pending" counts accepted mac_last beats that are still in the pipeline.
// This guarantees that every accepted result has a FIFO slot, so the
// pipeline never stalls.
//
// Configuration macro: DPE_SATURATE_EN
//   defined   : IW -> OW narrowing saturates to the signed OW range
//   undefined : IW -> OW narrowing keeps the low OW bits (wrap)
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   EN_mac        beat request (accepted when EN_mac && RDY_mac)
//   mac_vecA/B    packed signed vectors, lane i = [i*DW +: DW]
//   mac_last      final beat of the current dot product
//   RDY_mac       engine can accept a beat this cycle
//   EN_readMem    pop request for the oldest result
//   VALID_memVal  one-cycle pulse, memVal_data valid
//   memVal_data   popped result (holds between pops)
//   occupancy     number of results stored in the FIFO
// ============================================================================

// ----------------------------------------------------------------------------
// memory_wrapper_2port: port A synchronous read, port B write.
// Array contents are not reset. The read data register is reset.
// ----------------------------------------------------------------------------
module memory_wrapper_2port #(
  parameter int AW = 6,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cenA,
  input  logic [AW-1:0] addrA,
  output logic [W-1:0]  doutA,
  input  logic          wenB,
  input  logic [AW-1:0] addrB,
  input  logic [W-1:0]  dinB
);

  logic [W-1:0] r_mem [0:(1<<AW)-1];
  logic [W-1:0] r_dout;

  // Storage array write port (no reset on contents)
  always_ff @(posedge clk) begin
    if (wenB) begin
      r_mem[addrB] <= dinB;
    end
  end

  // Read port: data register only updates on a read, so it holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
    end else if (cenA) begin
      r_dout <= r_mem[addrA];
    end else begin
      r_dout <= r_dout;
    end
  end

  assign doutA = r_dout;

endmodule

// ----------------------------------------------------------------------------
// Top level
// ----------------------------------------------------------------------------
module dot_product_engine #(
  parameter int LANES    = 4,
  parameter int DW       = 16,
  parameter int OW       = 32,
  parameter int DEPTH    = 64,
  parameter int LOGDEPTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EN_mac,
  input  logic [LANES*DW-1:0]   mac_vecA,
  input  logic [LANES*DW-1:0]   mac_vecB,
  input  logic                  mac_last,
  output logic                  RDY_mac,
  input  logic                  EN_readMem,
  output logic                  VALID_memVal,
  output logic [OW-1:0]         memVal_data,
  output logic [LOGDEPTH:0]     occupancy
);

  localparam int LOG2L = $clog2(LANES);
  localparam int IW    = 2*DW + LOG2L + 8;
  localparam int CW    = LOGDEPTH + 2;
  localparam logic [LOGDEPTH:0] CNT_ONE = {{LOGDEPTH{1'b0}}, 1'b1};
  localparam logic [LOGDEPTH-1:0] PTR_ONE = {{(LOGDEPTH-1){1'b0}}, 1'b1};

  // Signed DW x DW product, sign-extended to the internal width.
  // Operands are extended to 2*DW first so the truncated product is exact.
  function automatic logic signed [IW-1:0] f_mul(input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
    logic signed [2*DW-1:0] ea;
    logic signed [2*DW-1:0] eb;
    logic signed [2*DW-1:0] p;
    ea = {{DW{a[DW-1]}}, a};
    eb = {{DW{b[DW-1]}}, b};
    p  = ea * eb;
    return {{(IW-2*DW){p[2*DW-1]}}, p};
  endfunction

  // IW -> OW narrowing
  function automatic logic [OW-1:0] f_narrow(input logic signed [IW-1:0] v);
`ifdef DPE_SATURATE_EN
    logic [IW-OW:0] hi;
    hi = v[IW-1:OW-1];
    if ((&hi) || !(|hi)) begin
      return v[OW-1:0];
    end else if (v[IW-1]) begin
      return {1'b1, {(OW-1){1'b0}}};
    end else begin
      return {1'b0, {(OW-1){1'b1}}};
    end
`else
    return v[OW-1:0];
`endif
  endfunction

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic                     r_rdy;
  logic                     w_acc;
  logic                     w_acc_last;
  logic signed [IW-1:0]     w_prod [0:LANES-1];
  logic signed [IW-1:0]     r_lvl  [0:LOG2L][0:LANES-1];
  logic [LOG2L:0]           r_vld;
  logic [LOG2L:0]           r_lst;
  logic signed [IW-1:0]     r_acc;
  logic signed [IW-1:0]     w_sum;
  logic [OW-1:0]            r_res;
  logic                     r_res_vld;
  logic                     w_wr;
  logic                     w_pop;
  logic [LOGDEPTH-1:0]      r_wr_ptr;
  logic [LOGDEPTH-1:0]      r_rd_ptr;
  logic [LOGDEPTH:0]        r_occ;
  logic [LOGDEPTH:0]        r_pend;
  logic [LOGDEPTH:0]        w_occ_nxt;
  logic [LOGDEPTH:0]        w_pend_nxt;
  logic [CW-1:0]            w_need;
  logic                     r_valid;
  logic [OW-1:0]            w_rd_data;

  assign w_acc      = EN_mac & r_rdy;
  assign w_acc_last = w_acc & mac_last;

  // Lane products for the beat being presented
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_prod[i] = f_mul(mac_vecA[i*DW +: DW], mac_vecB[i*DW +: DW]);
    end
  end

  // Product register and adder-tree levels, with valid/last tags alongside.
  // Level l holds LANES>>l live nodes. Remaining slots are held at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l <= LOG2L; l++) begin
        for (int j = 0; j < LANES; j++) begin
          r_lvl[l][j] <= '0;
        end
      end
      r_vld <= '0;
      r_lst <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        r_lvl[0][i] <= w_prod[i];
      end
      for (int l = 1; l <= LOG2L; l++) begin
        for (int j = 0; j < LANES/2; j++) begin
          if (j < (LANES >> l)) begin
            r_lvl[l][j] <= r_lvl[l-1][2*j] + r_lvl[l-1][2*j+1];
          end else begin
            r_lvl[l][j] <= '0;
          end
        end
        for (int j = LANES/2; j < LANES; j++) begin
          r_lvl[l][j] <= '0;
        end
      end
      r_vld <= {r_vld[LOG2L-1:0], w_acc};
      r_lst <= {r_lst[LOG2L-1:0], mac_last};
    end
  end

  assign w_sum = r_acc + r_lvl[LOG2L][0];

  // Accumulator: a last beat emits acc+treesum and restarts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_res     <= '0;
      r_res_vld <= 1'b0;
    end else if (r_vld[LOG2L]) begin
      if (r_lst[LOG2L]) begin
        r_res     <= f_narrow(w_sum);
        r_res_vld <= 1'b1;
        r_acc     <= '0;
      end else begin
        r_res     <= r_res;
        r_res_vld <= 1'b0;
        r_acc     <= w_sum;
      end
    end else begin
      r_res     <= r_res;
      r_res_vld <= 1'b0;
      r_acc     <= r_acc;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO control
  // --------------------------------------------------------------------------
  assign w_wr  = r_res_vld;
  assign w_pop = EN_readMem & (r_occ != '0);

  // Next occupancy and pending counts
  always_comb begin
    w_occ_nxt  = r_occ;
    w_pend_nxt = r_pend;
    case ({w_wr, w_pop})
      2'b10:   w_occ_nxt = r_occ + CNT_ONE;
      2'b01:   w_occ_nxt = r_occ - CNT_ONE;
      default: w_occ_nxt = r_occ;
    endcase
    case ({w_acc_last, w_wr})
      2'b10:   w_pend_nxt = r_pend + CNT_ONE;
      2'b01:   w_pend_nxt = r_pend - CNT_ONE;
      default: w_pend_nxt = r_pend;
    endcase
    w_need = {1'b0, w_occ_nxt} + {1'b0, w_pend_nxt};
  end

  // Pointers, counters, ready and read-valid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_pend   <= '0;
      r_rdy    <= 1'b1;
      r_valid  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_occ   <= w_occ_nxt;
      r_pend  <= w_pend_nxt;
      r_rdy   <= (w_need < CW'(DEPTH));
      r_valid <= w_pop;
    end
  end

  memory_wrapper_2port #(
    .AW (LOGDEPTH),
    .W  (OW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .cenA  (w_pop),
    .addrA (r_rd_ptr),
    .doutA (w_rd_data),
    .wenB  (w_wr),
    .addrB (r_wr_ptr),
    .dinB  (r_res)
  );

  assign RDY_mac      = r_rdy;
  assign VALID_memVal = r_valid;
  assign memVal_data  = w_rd_data;
  assign occupancy    = r_occ;

endmodule
